// File: rtl/sync_arith_unit_hs.sv
// Handshaked arithmetic unit: single-cycle shift/compare/sign-format conversion
// ops plus a restoring divider (quotient or remainder). The result is held until the consumer takes it.
module sync_arith_unit_hs #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [3:0]   iop,
  input  logic [M-1:0] iarg_A,
  input  logic [M-1:0] iarg_B,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status,
  output logic         o_busy
);
  localparam int SHW = $clog2(M);
  localparam logic [M-1:0]   M_LIM   = M'(M);
  localparam logic [SHW-1:0] CNT_END = SHW'(M - 1);

  localparam logic [3:0] OP_SHR   = 4'b0000;
  localparam logic [3:0] OP_CMP   = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_ZM2U2 = 4'b0011;
  localparam logic [3:0] OP_REM   = 4'b0100;
  localparam logic [3:0] OP_U22ZM = 4'b0101;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   quo_q, quo_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   rem_q, rem_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           is_rem_q, is_rem_d;
  logic [M-1:0]   result_q, result_d;
  logic [3:0]     status_q, status_d;

  // Status word: {ERROR, NOT_EVEN_1, ZEROS, OVERFLOW}; an error zeroes the result.
  function automatic logic [3:0] flags(input logic [M-1:0] r, input logic err, input logic ovf);
    if (err) flags = 4'b1010;
    else     flags = {1'b0, ^r, (r == '0), ovf};
  endfunction

  // Single-cycle ops, evaluated straight from the request inputs at accept time.
  logic [M-1:0]   sc_res, neg_a, sh_mask;
  logic [SHW-1:0] sh;
  logic           sc_err, sc_ovf;
  logic           a_neg, b_neg;
  logic [M-2:0]   mag_a, mag_b;

  always_comb begin
    sc_res  = '0;
    sc_err  = 1'b0;
    sc_ovf  = 1'b0;
    sh      = iarg_B[SHW-1:0];
    sh_mask = ~({M{1'b1}} << sh);
    neg_a   = -iarg_A;
    mag_a   = iarg_A[M-2:0];
    mag_b   = iarg_B[M-2:0];
    // A zero magnitude counts as non-negative so that +0 == -0.
    a_neg   = iarg_A[M-1] & (mag_a != '0);
    b_neg   = iarg_B[M-1] & (mag_b != '0);
    case (iop)
      OP_SHR: begin
        if (iarg_B >= M_LIM) sc_err = 1'b1;
        else begin
          sc_res = iarg_A >> sh;
          sc_ovf = |(iarg_A & sh_mask);
        end
      end
      OP_CMP: begin
        if (a_neg != b_neg) sc_res[0] = a_neg;
        else if (a_neg)     sc_res[0] = (mag_a > mag_b);
        else                sc_res[0] = (mag_a < mag_b);
      end
      OP_ZM2U2: sc_res = iarg_A[M-1] ? -{1'b0, mag_a} : iarg_A;
      OP_U22ZM: begin
        if (!iarg_A[M-1])     sc_res = iarg_A;
        else if (mag_a == '0) sc_ovf = 1'b1;
        else                  sc_res = {1'b1, neg_a[M-2:0]};
      end
      default: sc_err = 1'b1;  // unlisted opcodes, and DIV/REM by zero
    endcase
  end

  // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  logic [M:0]   rem_sh, diff;
  logic [M-1:0] rem_nxt, quo_nxt;

  always_comb begin
    rem_sh  = {rem_q, quo_q[M-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nxt = diff[M] ? rem_sh[M-1:0] : diff[M-1:0];
    quo_nxt = {quo_q[M-2:0], ~diff[M]};
  end

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (i_valid) begin
        if ((iop == OP_DIV || iop == OP_REM) && iarg_B != '0) begin
          state_d  = EXEC;
          quo_d    = iarg_A;
          dvs_d    = iarg_B;
          rem_d    = '0;
          cnt_d    = '0;
          is_rem_d = (iop == OP_REM);
        end else begin
          state_d  = DONE;
          result_d = sc_err ? '0 : sc_res;
          status_d = flags(sc_res, sc_err, sc_ovf);
        end
      end
      EXEC: begin
        quo_d = quo_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_END) begin
          state_d  = DONE;
          result_d = is_rem_q ? rem_nxt : quo_nxt;
          status_d = flags(is_rem_q ? rem_nxt : quo_nxt, 1'b0, 1'b0);
        end
      end
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q == EXEC);
  assign o_result = result_q;
  assign o_status = status_q;
endmodule

// File: tb/tb_sync_arith_unit_hs.sv
// Bench for sync_arith_unit_hs at M=8: directed vector table, handshake corner
// sequences and random ops against an arithmetic reference model.
module tb_sync_arith_unit_hs;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [3:0]   iop = 4'h0;
  logic [M-1:0] iarg_A = '0;
  logic [M-1:0] iarg_B = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;
  logic         o_busy;

  int checks = 0;
  int failures = 0;

  sync_arith_unit_hs #(.M(M)) dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .iop(iop), .iarg_A(iarg_A), .iarg_B(iarg_B), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_status(o_status), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] st;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: values interpreted as numbers, results from plain arithmetic.
  function automatic int zm_val(input logic [7:0] x);
    int mag;
    mag = int'(x[6:0]);
    return x[7] ? -mag : mag;
  endfunction

  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [3:0] s, output int lat);
    logic err;
    logic ovf;
    int   v;
    err = 1'b0; ovf = 1'b0; r = 8'h00; lat = 1;
    case (op)
      4'd0: if (b >= 8) err = 1'b1;
            else begin r = a >> b; ovf = (int'(a) % (1 << b)) != 0; end
      4'd1: r = (zm_val(a) < zm_val(b)) ? 8'd1 : 8'd0;
      4'd2: if (b == 0) err = 1'b1; else begin r = a / b; lat = 9; end
      4'd4: if (b == 0) err = 1'b1; else begin r = a % b; lat = 9; end
      4'd3: begin v = zm_val(a); r = v[7:0]; end
      4'd5: begin
        v = int'($signed(a));
        if (v == -128) ovf = 1'b1;
        else if (v < 0) begin v = -v; r = 8'h80 | v[7:0]; end
        else r = a;
      end
      default: err = 1'b1;
    endcase
    if (err) begin r = 8'h00; s = 4'b1010; end
    else s = {1'b0, ($countones(r) % 2) == 1, r == 8'h00, ovf};
  endtask

  // Issue one request, wait (bounded) for the result, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [3:0] s, output int lat);
    @(negedge clk);
    i_valid = 1'b1; iop = op; iarg_A = a; iarg_B = b;
    @(negedge clk);
    // Garbage after accept must not disturb the operation.
    i_valid = 1'b0; iop = 4'($urandom); iarg_A = 8'($urandom); iarg_B = 8'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin @(negedge clk); lat++; end
    r = o_result; s = o_status;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  vec_t vecs[$];
  logic [7:0] r, er, hold_r;
  logic [3:0] s, es, hold_s;
  int lat, elat;

  initial begin
    vecs.push_back('{4'h0, 8'hB6, 8'd3,   8'h16, 4'b0101, 1});
    vecs.push_back('{4'h2, 8'd200, 8'd7,  8'd28, 4'b0100, 9});
    vecs.push_back('{4'h4, 8'd200, 8'd7,  8'd4,  4'b0100, 9});
    vecs.push_back('{4'h2, 8'd200, 8'd0,  8'd0,  4'b1010, 1});
    vecs.push_back('{4'h4, 8'd5,   8'd0,  8'd0,  4'b1010, 1});
    vecs.push_back('{4'h1, 8'h85, 8'h83,  8'd1,  4'b0100, 1});
    vecs.push_back('{4'h1, 8'h80, 8'h00,  8'd0,  4'b0010, 1});
    vecs.push_back('{4'h1, 8'h00, 8'h80,  8'd0,  4'b0010, 1});
    vecs.push_back('{4'h1, 8'h83, 8'h05,  8'd1,  4'b0100, 1});
    vecs.push_back('{4'h3, 8'h85, 8'h00,  8'hFB, 4'b0100, 1});
    vecs.push_back('{4'h3, 8'h80, 8'h00,  8'h00, 4'b0010, 1});
    vecs.push_back('{4'h5, 8'h80, 8'h00,  8'h00, 4'b0011, 1});
    vecs.push_back('{4'h5, 8'hFB, 8'h00,  8'h85, 4'b0100, 1});
    vecs.push_back('{4'h0, 8'hFF, 8'd8,   8'h00, 4'b1010, 1});
    vecs.push_back('{4'h0, 8'hFF, 8'd7,   8'h01, 4'b0101, 1});
    vecs.push_back('{4'hF, 8'h12, 8'h34,  8'h00, 4'b1010, 1});
    vecs.push_back('{4'h4, 8'd9,  8'd3,   8'd0,  4'b0010, 9});
    vecs.push_back('{4'h2, 8'd255, 8'd1,  8'd255, 4'b0000, 9});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_result", int'(o_result), 0);
    chk("rst_status", int'(o_status), 0);
    chk("rst_valid",  int'(o_valid), 0);
    chk("rst_busy",   int'(o_busy), 0);
    chk("rst_ready",  int'(o_ready), 1);
    i_reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, s, lat);
      chk($sformatf("vec%0d_result", i), int'(r), int'(vecs[i].res));
      chk($sformatf("vec%0d_status", i), int'(s), int'(vecs[i].st));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_valid_drop", i), int'(o_valid), 0);
    end

    // Divider status while iterating
    @(negedge clk);
    i_valid = 1'b1; iop = 4'h2; iarg_A = 8'd100; iarg_B = 8'd9;
    @(negedge clk);
    i_valid = 1'b0;
    chk("exec_busy",  int'(o_busy), 1);
    chk("exec_ready", int'(o_ready), 0);
    chk("exec_valid", int'(o_valid), 0);
    lat = 1;
    while (!o_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("exec_latency", lat, 9);
    chk("exec_result", int'(o_result), 11);

    // Back-pressure: result held for 5 cycles while a new request is offered
    hold_r = o_result; hold_s = o_status;
    i_valid = 1'b1; iop = 4'h3; iarg_A = 8'h85; iarg_B = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_result", c), int'(o_result), int'(hold_r));
      chk($sformatf("bp%0d_status", c), int'(o_status), int'(hold_s));
      chk($sformatf("bp%0d_valid", c), int'(o_valid), 1);
      chk($sformatf("bp%0d_ready", c), int'(o_ready), 0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("bp_valid_drop", int'(o_valid), 0);
    chk("bp_ready_back", int'(o_ready), 1);
    @(negedge clk);
    chk("bp_req_ignored", int'(o_valid), 0);

    // Reset during EXEC cycle 4 aborts the divide
    i_valid = 1'b1; iop = 4'h2; iarg_A = 8'd200; iarg_B = 8'd7;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", int'(o_busy), 1);
    i_reset = 1'b0;
    #1;
    chk("abort_result", int'(o_result), 0);
    chk("abort_status", int'(o_status), 0);
    chk("abort_valid",  int'(o_valid), 0);
    chk("abort_busy",   int'(o_busy), 0);
    chk("abort_ready",  int'(o_ready), 1);
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_output", int'(o_valid), 0);
    run_op(4'h2, 8'd9, 8'd3, r, s, lat);
    chk("post_abort_result",  int'(r), 3);
    chk("post_abort_status",  int'(s), 4'b0000);
    chk("post_abort_latency", lat, 9);

    // Random ops against the model
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      int sel;
      sel = $urandom_range(0, 7);
      op  = (sel <= 5) ? 4'(sel) : 4'($urandom_range(6, 15));
      a   = 8'($urandom);
      b   = 8'($urandom);
      if (op == 4'h0) b = 8'($urandom_range(0, 9));
      if ((op == 4'h2 || op == 4'h4) && $urandom_range(0, 9) == 0) b = 8'h00;
      model(op, a, b, er, es, elat);
      run_op(op, a, b, r, s, lat);
      chk($sformatf("rnd%0d_op%0h_a%0h_b%0h_result", n, op, a, b), int'(r), int'(er));
      chk($sformatf("rnd%0d_op%0h_a%0h_b%0h_status", n, op, a, b), int'(s), int'(es));
      chk($sformatf("rnd%0d_latency", n), lat, elat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
